// File: rtl/mul_gate_pkg.sv
// mul_gate_pkg: opcodes, FSM state encoding and golden function of the mulGate selectable gate
package mul_gate_pkg;
  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_XNOR = 2'b11;
  typedef logic [0:0] state_t;
  localparam state_t IDLE   = 1'b0;
  localparam state_t SETTLE = 1'b1;
  function automatic logic gate_eval(input logic [1:0] sel, input logic a, input logic b);
    return sel == OP_AND ? a & b : sel == OP_OR ? a | b : sel == OP_XOR ? a ^ b : ~(a ^ b);
  endfunction
endpackage

// File: rtl/mul_gate_checker_if.sv
// mul_gate_checker_if: vector handshake between a vector source (master) and the checker (slave)
//   vec_valid/vec_ready handshake, vec_sel opcode, vec_a/vec_b operands
interface mul_gate_checker_if;
  logic       vec_valid;
  logic       vec_ready;
  logic [1:0] vec_sel;
  logic       vec_a;
  logic       vec_b;
  modport master (output vec_valid, vec_sel, vec_a, vec_b, input vec_ready);
  modport slave  (input vec_valid, vec_sel, vec_a, vec_b, output vec_ready);
endinterface

// File: rtl/mul_gate_model.sv
// mul_gate_model: combinational golden model of the gate
//   sel/a/b in, z = golden output
module mul_gate_model
  import mul_gate_pkg::*;
(
  input  logic [1:0] sel,
  input  logic       a,
  input  logic       b,
  output logic       z
);
  assign z = gate_eval(sel, a, b);
endmodule

// File: rtl/mul_gate_checker.sv
// mul_gate_checker: drives vectors into the gate, samples z after a settle time and scores it
//   clk/rst_n, vec (handshake slave), dut_sel/dut_a/dut_b drive, dut_z response, clr counter clear,
//   chk_valid/chk_pass result pulse, exp_z golden value, pass_cnt/fail_cnt, cov/all_covered coverage
module mul_gate_checker
  import mul_gate_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  mul_gate_checker_if.slave  vec,
  output logic [1:0]         dut_sel,
  output logic               dut_a,
  output logic               dut_b,
  input  logic               dut_z,
  input  logic               clr,
  output logic               chk_valid,
  output logic               chk_pass,
  output logic               exp_z,
  output logic [CNT_W-1:0]   pass_cnt,
  output logic [CNT_W-1:0]   fail_cnt,
  output logic [3:0]         cov,
  output logic               all_covered
);
  localparam int SW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] LAST = SW'(SETTLE_CYCLES - 1);
  state_t        state;
  logic [SW-1:0] cnt;
  logic          acc;
  logic          done;
  logic          pass;
  assign vec.vec_ready = state == IDLE;
  assign acc = vec.vec_valid & vec.vec_ready;
  assign done = state == SETTLE && cnt == LAST;
  assign pass = dut_z == exp_z;
  assign all_covered = &cov;
  mul_gate_model u_model (.sel(dut_sel), .a(dut_a), .b(dut_b), .z(exp_z));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      dut_sel   <= OP_AND;
      dut_a     <= 1'b0;
      dut_b     <= 1'b0;
      chk_valid <= 1'b0;
      chk_pass  <= 1'b0;
    end else begin
      state     <= acc ? SETTLE : done ? IDLE : state;
      cnt       <= acc ? '0 : state == SETTLE ? cnt + 1'b1 : cnt;
      chk_valid <= done;
      if (acc) begin
        dut_sel <= vec.vec_sel;
        dut_a   <= vec.vec_a;
        dut_b   <= vec.vec_b;
      end
      if (done) chk_pass <= pass;
    end
  // clear beats a coinciding check; saturating counters never wrap
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pass_cnt <= '0;
      fail_cnt <= '0;
      cov      <= '0;
    end else if (clr) begin
      pass_cnt <= '0;
      fail_cnt <= '0;
      cov      <= '0;
    end else if (done) begin
      pass_cnt <= pass_cnt + CNT_W'(pass && !(&pass_cnt));
      fail_cnt <= fail_cnt + CNT_W'(!pass && !(&fail_cnt));
      cov      <= cov | (4'b0001 << dut_sel);
    end
endmodule
